// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: mode encoding,
// FSM states and the slice-counter width helper.
package serial_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for n slice steps; never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_addsub_slice.sv
// DIGIT-bit ripple adder slice built from full_adder cells; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module addsub_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .sum(sum[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit slice per clock,
// start/done handshake, registered result and flags.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;

  logic [DIGIT-1:0] sum_s;
  logic             co_s;
  logic             c_msb_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (a_r[DIGIT-1:0]),
    .y    (b_r[DIGIT-1:0]),
    .ci   (carry_r),
    .sum  (sum_s),
    .co   (co_s),
    .c_msb(c_msb_s)
  );

  // New slice enters at the top, so after N steps the LSB slice has reached bit 0.
  assign res_next_s = (res_r >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));
  assign last_s     = (cnt_r == CW'(N - 1));

  // Handshake FSM, operand/result shifting and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{m == MODE_SUB}};
            carry_r <= (m == MODE_SUB);
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          res_r   <= res_next_s;
          carry_r <= co_s;
          if (last_s) begin
            s       <= res_next_s;
            cout    <= co_s;
            ovf     <= c_msb_s ^ co_s;
            zero    <= (res_next_s == '0);
            neg     <= res_next_s[WIDTH-1];
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: three parameterisations, directed
// corner cases and random operations against an arithmetic reference model.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [3];
  logic        m_v     [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic [15:0] s_v     [3];
  logic        cout_v  [3];
  logic        ovf_v   [3];
  logic        zero_v  [3];
  logic        neg_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] s16;
  logic [3:0]  s4;
  logic [7:0]  s8;

  assign s_v[0] = s16;
  assign s_v[1] = {12'd0, s4};
  assign s_v[2] = {8'd0, s8};

  int wdt[3]    = '{16, 4, 8};
  int nsteps[3] = '{4, 1, 8};
  int errors = 0;
  int checks = 0;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .m(m_v[0]),
    .a(a_v[0]), .b(b_v[0]), .s(s16), .cout(cout_v[0]), .ovf(ovf_v[0]),
    .zero(zero_v[0]), .neg(neg_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  serial_addsub #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .m(m_v[1]),
    .a(a_v[1][3:0]), .b(b_v[1][3:0]), .s(s4), .cout(cout_v[1]), .ovf(ovf_v[1]),
    .zero(zero_v[1]), .neg(neg_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .m(m_v[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .s(s8), .cout(cout_v[2]), .ovf(ovf_v[2]),
    .zero(zero_v[2]), .neg(neg_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic m,
                       output logic [15:0] s, output logic c, output logic o,
                       output logic z, output logic n);
    int ua, ub, half, sa, sb, sres, ures;
    half = 1 << (w - 1);
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    if (m == MODE_SUB) begin
      ures = ua - ub;
      sres = sa - sb;
      c = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c = (ures >= 2 * half);
    end
    s = 16'(ures & ((1 << w) - 1));
    o = (sres < -half) || (sres > half - 1);
    z = (s == 16'd0);
    n = s[w-1];
  endtask

  task automatic check_result(input int k, input logic [15:0] a, input logic [15:0] b,
                              input logic m);
    logic [15:0] es;
    logic ec, eo, ez, en;
    model(wdt[k], a, b, m, es, ec, eo, ez, en);
    check("s", s_v[k], es);
    check("cout", cout_v[k], ec);
    check("ovf", ovf_v[k], eo);
    check("zero", zero_v[k], ez);
    check("neg", neg_v[k], en);
    check("busy_end", busy_v[k], 1'b0);
  endtask

  // Caller must be mid-cycle; returns at posedge+1 of the done cycle.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic m);
    int edges;
    start_v[k] = 1'b1; a_v[k] = a; b_v[k] = b; m_v[k] = m;
    @(posedge clk); #1;
    edges = 1;
    start_v[k] = 1'b0; a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); m_v[k] = ~m;
    check("busy_start", busy_v[k], 1'b1);
    while (done_v[k] !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, nsteps[k] + 1);
    check_result(k, a, b, m);
  endtask

  task automatic check_all_zero(input int k);
    check("rst_s", s_v[k], 16'd0);
    check("rst_cout", cout_v[k], 1'b0);
    check("rst_ovf", ovf_v[k], 1'b0);
    check("rst_zero", zero_v[k], 1'b0);
    check("rst_neg", neg_v[k], 1'b0);
    check("rst_busy", busy_v[k], 1'b0);
    check("rst_done", done_v[k], 1'b0);
  endtask

  initial begin
    int edges;
    int ndone;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; m_v[k] = MODE_ADD; a_v[k] = 16'd0; b_v[k] = 16'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_all_zero(k);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on the 16/4 instance
    run_op(0, 16'h1234, 16'h0FFF, MODE_ADD);
    check("s_1234", s_v[0], 16'h2233);
    @(posedge clk); #1;
    check("done_pulse", done_v[0], 1'b0);
    @(negedge clk);
    run_op(0, 16'hFFFF, 16'h0001, MODE_ADD);
    check("zero_wrap", zero_v[0], 1'b1);
    @(negedge clk);
    run_op(0, 16'h7FFF, 16'h0001, MODE_ADD);
    check("ovf_add", ovf_v[0], 1'b1);
    @(negedge clk);
    run_op(0, 16'h0003, 16'h0004, MODE_SUB);
    check("borrow", cout_v[0], 1'b0);
    @(negedge clk);
    run_op(0, 16'h8000, 16'h0001, MODE_SUB);
    check("ovf_sub", ovf_v[0], 1'b1);
    @(negedge clk);

    // Start while busy is ignored; then back-to-back start in the done cycle
    start_v[0] = 1'b1; a_v[0] = 16'h1111; b_v[0] = 16'h2222; m_v[0] = MODE_ADD;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF; m_v[0] = MODE_ADD;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    edges = 3;
    while (done_v[0] !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("ign_latency", edges, 5);
    check("ign_s", s_v[0], 16'h3333);
    run_op(0, 16'h0F0F, 16'h0101, MODE_SUB);
    @(posedge clk); #1;
    check("b2b_done_pulse", done_v[0], 1'b0);
    @(negedge clk);

    // Reset in the middle of an operation abandons it
    start_v[0] = 1'b1; a_v[0] = 16'h0001; b_v[0] = 16'h0002; m_v[0] = MODE_ADD;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero(0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) ndone++;
    end
    check("no_done_after_rst", ndone, 0);
    check("idle_after_rst", busy_v[0], 1'b0);
    @(negedge clk);
    run_op(0, 16'h0042, 16'h0017, MODE_ADD);
    @(negedge clk);

    // Narrow instances
    run_op(1, 16'h000B, 16'h000A, MODE_SUB);
    check("w4_s", s_v[1], 16'h0001);
    @(negedge clk);
    run_op(2, 16'h00FF, 16'h0001, MODE_ADD);
    check("w8_zero", zero_v[2], 1'b1);
    @(negedge clk);

    // Random operations on every instance
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        run_op(k, ra, rb, 1'($urandom));
        if (i % 3 == 0) @(negedge clk);
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
